// File: rtl/spi_flash_fetch.sv
// SPI READ fetch engine: turns one word-fetch request into a mode-0 flash READ frame
// (opcode, address, 32 data bits) and returns the word little-endian.
module spi_flash_fetch #(
  parameter logic [7:0] READ_CMD = 8'h03,
  parameter int         ADDR_W   = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              spi_cs_n,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam int N     = 8 + ADDR_W + 32;
  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] FIRST_DATA = CNT_W'(8 + ADDR_W);
  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  logic [N-1:0]     tx_sr;
  logic [CNT_W-1:0] bit_cnt;
  logic [31:0]      rx_sr;
  logic [31:0]      rx_word;

  assign req_ready = (state == IDLE);

  // Word as received on the wire, first byte in [31:24].
  assign rx_word = {rx_sr[30:0], spi_miso};

  // NOTE: all state uses non-blocking assignments so every register sees the
  // pre-edge values of the others, regardless of statement order in the block.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; rst is just a high-priority branch inside the
    // clocked block and takes effect on the next edge, aborting any transaction.
    if (rst) begin
      state     <= IDLE;
      spi_cs_n  <= 1'b1;
      spi_sclk  <= 1'b0;
      spi_mosi  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      tx_sr     <= '0;
      bit_cnt   <= '0;
      rx_sr     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            tx_sr    <= {READ_CMD, req_addr, 32'b0};
            spi_cs_n <= 1'b0;
            spi_sclk <= 1'b0;
            spi_mosi <= READ_CMD[7];
            bit_cnt  <= '0;
            state    <= SHIFT;
          end
        end

        SHIFT: begin
          spi_sclk <= ~spi_sclk;
          // Falling SCLK: sample MISO, advance MOSI to the next frame bit.
          if (spi_sclk) begin
            tx_sr    <= tx_sr << 1;
            spi_mosi <= tx_sr[N-2];
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt >= FIRST_DATA) begin
              rx_sr <= rx_word;
            end
            if (bit_cnt == LAST_BIT) begin
              spi_cs_n  <= 1'b1;
              spi_mosi  <= 1'b0;
              rsp_valid <= 1'b1;
              rsp_data  <= {rx_word[7:0], rx_word[15:8], rx_word[23:16], rx_word[31:24]};
              state     <= DONE;
            end
          end
        end

        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_flash_fetch.sv
// Scoreboard bench for spi_flash_fetch: a byte-array flash model answers READ frames,
// a negedge monitor checks MOSI frames, SCLK counts, latency and returned words.
module tb_spi_flash_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [23:0] req_addr = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        spi_cs_n;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_miso = 1'b0;

  spi_flash_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .spi_cs_n  (spi_cs_n),
    .spi_sclk  (spi_sclk),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] data;
    int          e0;
  } exp_t;

  exp_t        sb[$];
  logic [23:0] frame_q[$];
  logic [7:0]  mem[0:1023];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- flash model + monitor, all sampled at negedge ----------------
  logic        prev_sclk = 1'b0;
  logic        prev_cs = 1'b1;
  logic        prev_rv = 1'b0;
  int          rise_cnt = 0;
  int          fall_cnt = 0;
  int          cs_high = 0;
  int          flash_addr = 0;
  int          idx;
  int          rsp_cnt = 0;
  bit          abort_pending = 1'b0;
  logic [63:0] frame = '0;
  logic [7:0]  fbyte;
  logic [23:0] fa;
  exp_t        e;

  always @(negedge clk) begin
    if (prev_cs === 1'b1 && spi_cs_n === 1'b0) begin
      check("cs_gap", cs_high >= 1, 1);
      rise_cnt = 0;
      fall_cnt = 0;
      frame    = '0;
      spi_miso = 1'b0;
    end
    if (spi_cs_n === 1'b1) cs_high++;
    else cs_high = 0;

    if (spi_cs_n === 1'b0 && spi_sclk === 1'b1 && prev_sclk === 1'b0) begin
      rise_cnt++;
      frame = {frame[62:0], spi_mosi};
    end
    // Flash shifts out the next data bit after each falling SCLK.
    if (spi_cs_n === 1'b0 && spi_sclk === 1'b0 && prev_sclk === 1'b1) begin
      fall_cnt++;
      if (fall_cnt == 32) flash_addr = int'(frame[23:0]);
      if (fall_cnt >= 32 && fall_cnt < 64) begin
        idx      = fall_cnt - 32;
        fbyte    = mem[(flash_addr + idx / 8) % 1024];
        spi_miso = fbyte[7 - idx % 8];
      end
    end

    if (prev_cs === 1'b0 && spi_cs_n === 1'b1) begin
      if (abort_pending) begin
        check("abort_frame_short", rise_cnt < 64, 1);
        abort_pending = 1'b0;
      end else begin
        check("sclk_rises", rise_cnt, 64);
        if (frame_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
        end else begin
          fa = frame_q.pop_front();
          check("mosi_cmd_addr", frame[63:32], {8'h03, fa});
          check("mosi_data_zero", frame[31:0], 0);
        end
      end
      spi_miso = 1'b0;
    end

    if (!rst) begin
      if (rsp_valid === 1'b1 && prev_rv !== 1'b1) begin
        if (sb.size() == 0) check("unexpected_rsp", 1, 0);
        else check("latency", cyc - sb[0].e0, 128);
      end
      if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_handshake", 1, 0);
        end else begin
          e = sb.pop_front();
          check("rsp_data", rsp_data, e.data);
        end
        rsp_cnt++;
      end
    end

    prev_sclk = spi_sclk;
    prev_cs   = spi_cs_n;
    prev_rv   = rsp_valid;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [23:0] a, input logic [31:0] d, input bit track,
                       output int e0);
    bit found = 1'b0;
    e0        = 0;
    req_addr  = a;
    req_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (req_ready) begin
        tick();
        e0    = cyc;
        found = 1'b1;
        break;
      end
      tick();
    end
    req_valid = 1'b0;
    check("accept_timeout", found, 1);
    if (found && track) begin
      sb.push_back('{data: d, e0: e0});
      frame_q.push_back(a);
    end
  endtask

  task automatic wait_rsp(input int n);
    for (int i = 0; i < 400; i++) begin
      if (rsp_cnt >= n) break;
      tick();
    end
    check("rsp_timeout", rsp_cnt >= n, 1);
  endtask

  int e0;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[256] = 8'h13; mem[257] = 8'h37; mem[258] = 8'hC0; mem[259] = 8'hDE;
    mem[512] = 8'hFF; mem[513] = 8'hFF; mem[514] = 8'hFF; mem[515] = 8'hFF;

    // Reset held for two edges.
    rst = 1'b1;
    tick();
    tick();
    check("rst_cs_n", spi_cs_n, 1);
    check("rst_sclk", spi_sclk, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_req_ready", req_ready, 1);
    rst = 1'b0;
    tick();

    // Fetch 0x000100 under backpressure; a new request during DONE must be ignored.
    rsp_ready = 1'b0;
    issue(24'h000100, 32'hDEC03713, 1'b1, e0);
    for (int i = 0; i < 400; i++) begin
      if (rsp_valid) break;
      tick();
    end
    check("valid_timeout", rsp_valid, 1);
    req_addr  = 24'h000200;
    req_valid = 1'b1;
    repeat (10) begin
      tick();
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_data", rsp_data, 32'hDEC03713);
      check("bp_req_ready", req_ready, 0);
      check("bp_cs_n", spi_cs_n, 1);
      check("bp_sclk", spi_sclk, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick();
    check("hs_rsp_valid", rsp_valid, 0);
    check("hs_req_ready", req_ready, 1);
    check("hs_no_queued_req", spi_cs_n, 1);
    check("hs_rsp_count", rsp_cnt, 1);

    // Back-to-back fetches with the consumer always ready.
    rsp_ready = 1'b1;
    issue(24'h000000, 32'h59585B5A, 1'b1, e0);
    issue(24'h000004, 32'h5D5C5F5E, 1'b1, e0);
    wait_rsp(3);

    // Unaligned byte address is sent verbatim.
    issue(24'h000101, 32'h5EDEC037, 1'b1, e0);
    wait_rsp(4);

    // Reset sampled at edge E0+40 aborts the frame with no response.
    abort_pending = 1'b1;
    issue(24'h000100, 32'h0, 1'b0, e0);
    while (cyc < e0 + 39) tick();
    rst = 1'b1;
    tick();
    check("abort_cs_n", spi_cs_n, 1);
    check("abort_sclk", spi_sclk, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_req_ready", req_ready, 1);
    rst = 1'b0;
    repeat (150) tick();
    check("abort_no_rsp", rsp_cnt, 4);
    check("abort_cs_seen", abort_pending, 0);

    // Fresh full frame after the abort; all-ones data.
    issue(24'h000200, 32'hFFFFFFFF, 1'b1, e0);
    wait_rsp(5);

    tick();
    check("sb_empty", sb.size(), 0);
    check("frames_empty", frame_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
